// File: rtl/tdm_demux16x16.sv
// Time-division demultiplexer: steers slot k of each framed 16-bit word stream
// to output word Qk. Slots 0..NSLOT-2 collect in a shadow bank; the last slot
// bypasses it so all NSLOT outputs update together on the completing edge.
//
// Ports:
//   CLK      system clock, rising edge
//   RST      asynchronous active-high reset
//   D        input word
//   DV       data valid; D accepted on any rising edge with DV=1
//   FS       frame start (qualified by DV); marks D as slot 0
//   Q0..Q15  registered output words; Q(NSLOT)..Q15 are held at 0
//   UPD      one-cycle strobe: Q0..Q15 updated on this edge
//   ERR      one-cycle strobe: a partial frame was aborted by an early FS
//   SYNC     level: aligned to a frame
module tdm_demux16x16 #(
  parameter int unsigned NSLOT = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] D,
  input  logic        DV,
  input  logic        FS,
  output logic [15:0] Q0,
  output logic [15:0] Q1,
  output logic [15:0] Q2,
  output logic [15:0] Q3,
  output logic [15:0] Q4,
  output logic [15:0] Q5,
  output logic [15:0] Q6,
  output logic [15:0] Q7,
  output logic [15:0] Q8,
  output logic [15:0] Q9,
  output logic [15:0] Q10,
  output logic [15:0] Q11,
  output logic [15:0] Q12,
  output logic [15:0] Q13,
  output logic [15:0] Q14,
  output logic [15:0] Q15,
  output logic        UPD,
  output logic        ERR,
  output logic        SYNC
);

  localparam int unsigned NumSh = NSLOT - 1;
  localparam logic [3:0]  LastSlot = 4'(NSLOT - 1);

  logic [15:0] sh_q [NumSh];
  logic [15:0] sh_d [NumSh];
  logic [15:0] q_q  [16];
  logic [15:0] q_d  [16];
  logic [3:0]  sc_q, sc_d;
  logic        sync_q, sync_d;
  logic        upd_q, upd_d;
  logic        err_q, err_d;

  always_comb begin
    sh_d   = sh_q;
    q_d    = q_q;
    sc_d   = sc_q;
    sync_d = sync_q;
    upd_d  = 1'b0;
    err_d  = 1'b0;

    if (DV) begin
      if (FS) begin
        // FS while mid-frame discards the partial frame; Q keeps the last full one.
        if (sync_q && (sc_q != 4'd0)) begin
          err_d = 1'b1;
        end
        sh_d[0] = D;
        sc_d    = 4'd1;
        sync_d  = 1'b1;
      end else if (sync_q) begin
        if (sc_q == LastSlot) begin
          for (int k = 0; k < int'(NumSh); k++) begin
            q_d[k] = sh_q[k];
          end
          q_d[NSLOT-1] = D;
          upd_d        = 1'b1;
          sc_d         = 4'd0;
        end else begin
          // SC=0 without FS is still slot 0 (free-running alignment).
          for (int k = 0; k < int'(NumSh); k++) begin
            if (sc_q == 4'(k)) begin
              sh_d[k] = D;
            end
          end
          sc_d = sc_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < int'(NumSh); k++) begin
        sh_q[k] <= 16'h0000;
      end
      for (int k = 0; k < 16; k++) begin
        q_q[k] <= 16'h0000;
      end
      sc_q   <= 4'd0;
      sync_q <= 1'b0;
      upd_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      q_q    <= q_d;
      sc_q   <= sc_d;
      sync_q <= sync_d;
      upd_q  <= upd_d;
      err_q  <= err_d;
    end
  end

  assign Q0   = q_q[0];
  assign Q1   = q_q[1];
  assign Q2   = q_q[2];
  assign Q3   = q_q[3];
  assign Q4   = q_q[4];
  assign Q5   = q_q[5];
  assign Q6   = q_q[6];
  assign Q7   = q_q[7];
  assign Q8   = q_q[8];
  assign Q9   = q_q[9];
  assign Q10  = q_q[10];
  assign Q11  = q_q[11];
  assign Q12  = q_q[12];
  assign Q13  = q_q[13];
  assign Q14  = q_q[14];
  assign Q15  = q_q[15];
  assign UPD  = upd_q;
  assign ERR  = err_q;
  assign SYNC = sync_q;

endmodule

// File: tb/tb_tdm_demux16x16.sv
// Directed bench: one 16-slot instance and one 4-slot instance share stimulus.
module tb_tdm_demux16x16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d   = 16'h0000;
  logic        dv  = 1'b0;
  logic        fs  = 1'b0;

  logic [15:0] q16 [16];
  logic [15:0] q4  [16];
  logic        upd16, err16, sync16;
  logic        upd4, err4, sync4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_demux16x16 #(.NSLOT(16)) dut16 (
    .CLK(clk), .RST(rst), .D(d), .DV(dv), .FS(fs),
    .Q0(q16[0]), .Q1(q16[1]), .Q2(q16[2]), .Q3(q16[3]),
    .Q4(q16[4]), .Q5(q16[5]), .Q6(q16[6]), .Q7(q16[7]),
    .Q8(q16[8]), .Q9(q16[9]), .Q10(q16[10]), .Q11(q16[11]),
    .Q12(q16[12]), .Q13(q16[13]), .Q14(q16[14]), .Q15(q16[15]),
    .UPD(upd16), .ERR(err16), .SYNC(sync16)
  );

  tdm_demux16x16 #(.NSLOT(4)) dut4 (
    .CLK(clk), .RST(rst), .D(d), .DV(dv), .FS(fs),
    .Q0(q4[0]), .Q1(q4[1]), .Q2(q4[2]), .Q3(q4[3]),
    .Q4(q4[4]), .Q5(q4[5]), .Q6(q4[6]), .Q7(q4[7]),
    .Q8(q4[8]), .Q9(q4[9]), .Q10(q4[10]), .Q11(q4[11]),
    .Q12(q4[12]), .Q13(q4[13]), .Q14(q4[14]), .Q15(q4[15]),
    .UPD(upd4), .ERR(err4), .SYNC(sync4)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one word at the falling edge; return #1 after the accepting rising edge.
  task automatic send(input logic [15:0] w, input logic v, input logic f);
    @(negedge clk);
    d  = w;
    dv = v;
    fs = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check_q16(input string tag, input logic [15:0] base, input logic inc);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("%s_q%0d", tag, k), q16[k], inc ? base + 16'(k) : base);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    dv  = 1'b0;
    fs  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    check_q16("rst", 16'h0000, 1'b0);
    check("rst_upd", 16'(upd16), 16'd0);
    check("rst_err", 16'(err16), 16'd0);
    check("rst_sync", 16'(sync16), 16'd0);
    do_reset();

    // Continuous frame 0x1000+k
    for (int k = 0; k < 16; k++) begin
      send(16'h1000 + 16'(k), 1'b1, k == 0);
      if (k < 15) check($sformatf("f1_upd_w%0d", k), 16'(upd16), 16'd0);
      if (k == 14) check("f1_q0_pre", q16[0], 16'h0000);
    end
    check("f1_upd", 16'(upd16), 16'd1);
    check("f1_err", 16'(err16), 16'd0);
    check_q16("f1", 16'h1000, 1'b1);
    send(16'h0000, 1'b0, 1'b0);
    check("f1_upd_drop", 16'(upd16), 16'd0);

    // DV toggling with idle cycles; an FS during DV=0 must be ignored
    for (int k = 0; k < 16; k++) begin
      send(16'h3000 + 16'(k), 1'b1, k == 0);
      if (k < 15) begin
        check($sformatf("f2_upd_w%0d", k), 16'(upd16), 16'd0);
        check($sformatf("f2_q0_hold_w%0d", k), q16[0], 16'h1000);
        send(16'hFFFF, 1'b0, 1'b1);
        check($sformatf("f2_upd_gap%0d", k), 16'(upd16), 16'd0);
      end
    end
    check("f2_upd", 16'(upd16), 16'd1);
    check("f2_err", 16'(err16), 16'd0);
    check_q16("f2", 16'h3000, 1'b1);

    // Unframed words after reset are dropped until FS
    do_reset();
    for (int k = 0; k < 3; k++) begin
      send(16'hBAD0 + 16'(k), 1'b1, 1'b0);
      check($sformatf("f3_nosync%0d", k), 16'(sync16), 16'd0);
    end
    for (int k = 0; k < 16; k++) begin
      send(16'hA000 + 16'(k), 1'b1, k == 0);
      if (k == 0) check("f3_sync", 16'(sync16), 16'd1);
    end
    check("f3_upd", 16'(upd16), 16'd1);
    check("f3_q0", q16[0], 16'hA000);
    check("f3_q15", q16[15], 16'hA00F);

    // Early FS aborts a partial frame
    for (int k = 0; k < 16; k++) send(16'h5555, 1'b1, k == 0);
    check_q16("f4a", 16'h5555, 1'b0);
    for (int k = 0; k < 7; k++) send(16'h7777, 1'b1, 1'b0);
    check("f4_err_pre", 16'(err16), 16'd0);
    for (int k = 0; k < 16; k++) begin
      send(16'h2000 + 16'(k), 1'b1, k == 0);
      if (k == 0) begin
        check("f4_err", 16'(err16), 16'd1);
        check("f4_sync", 16'(sync16), 16'd1);
        check("f4_q0_hold", q16[0], 16'h5555);
      end
      if (k == 1) check("f4_err_clr", 16'(err16), 16'd0);
      if (k == 14) check("f4_q15_hold", q16[15], 16'h5555);
    end
    check("f4_upd", 16'(upd16), 16'd1);
    check_q16("f4b", 16'h2000, 1'b1);

    // Asynchronous reset mid-frame, away from the clock edge
    for (int k = 0; k < 10; k++) send(16'h9000 + 16'(k), 1'b1, k == 0);
    dv = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_q16("f5_rst", 16'h0000, 1'b0);
    check("f5_sync", 16'(sync16), 16'd0);
    #2;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) send(16'hB000 + 16'(k), 1'b1, k == 0);
    check("f5_upd", 16'(upd16), 16'd1);
    check_q16("f5", 16'hB000, 1'b1);

    // NSLOT=4 back-to-back frames
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        send(16'h00C0 + 16'(k), 1'b1, k == 0);
        check($sformatf("n4_upd_f%0d_w%0d", f, k), 16'(upd4), (k == 3) ? 16'd1 : 16'd0);
        check($sformatf("n4_err_f%0d_w%0d", f, k), 16'(err4), 16'd0);
        check($sformatf("n4_q4_f%0d_w%0d", f, k), q4[4], 16'h0000);
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("n4_f%0d_q%0d", f, k), q4[k], 16'h00C0 + 16'(k));
      end
      for (int k = 4; k < 16; k++) begin
        check($sformatf("n4_f%0d_q%0d", f, k), q4[k], 16'h0000);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
